mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified instruction/data memory of the multi-cycle CPU between the CPU controller path and a debug/loader port. The block sits between the requesters and the memory array. It serialises one transaction at a time and sequences the memory enable, write strobe and read-latency wait. It returns a one-cycle completion pulse and registered read data to the port that owns the transaction.

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter serialising CPU and debug/loader accesses onto one shared memory.
// Define MEM_ARB_CPU_PRIO_EN for fixed CPU priority; round-robin otherwise.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  localparam logic OwnCpu = 1'b0;
  localparam logic OwnDbg = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dbg_gnt_q, dbg_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dbg_done_q, dbg_done_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;
  logic              win_dbg;

  always_comb begin
`ifdef MEM_ARB_CPU_PRIO_EN
    win_dbg = dbg_req & ~cpu_req;
`else
    // On a tie the port that was not granted last time wins.
    win_dbg = dbg_req & (~cpu_req | (last_owner_q == OwnCpu));
`endif
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_req | dbg_req) begin
          state_d      = StAccess;
          owner_d      = win_dbg;
          last_owner_d = win_dbg;
          we_d         = win_dbg ? dbg_we    : cpu_we;
          mem_addr_d   = win_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_d  = win_dbg ? dbg_wdata : cpu_wdata;
        end
      end
      StAccess: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          cnt_d   = 3'(MEM_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StDone;
          if (owner_q == OwnDbg) begin
            dbg_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes are registered, so they are decoded from the state being entered.
    mem_en_d   = (state_d == StAccess);
    mem_we_d   = (state_d == StAccess) & we_d;
    cpu_gnt_d  = (state_d == StAccess) & (owner_d == OwnCpu);
    dbg_gnt_d  = (state_d == StAccess) & (owner_d == OwnDbg);
    cpu_done_d = (state_d == StDone) & (owner_d == OwnCpu);
    dbg_done_d = (state_d == StDone) & (owner_d == OwnDbg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnCpu;
      last_owner_q <= OwnDbg;
      we_q         <= 1'b0;
      cnt_q        <= 3'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_done_q   <= 1'b0;
      dbg_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_done_q   <= cpu_done_d;
      dbg_done_q   <= dbg_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign dbg_gnt   = dbg_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign dbg_done  = dbg_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic against a
// transaction-level model (arbitration rule, latency formula, reference memory).
module tb_mem_arbiter;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [31:0]   dbg_wdata = '0;
  logic          cpu_gnt, cpu_done, dbg_gnt, dbg_done;
  logic [31:0]   cpu_rdata, dbg_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_done  (dbg_done),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // Memory array: data is valid only in the cycle LAT cycles after the mem_en edge.
  logic [31:0] sim_mem [1024];
  bit          sim_vld [1024];
  logic [31:0] pipe [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      sim_mem[mem_addr] <= mem_wdata;
      sim_vld[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      pipe[0] <= sim_vld[mem_addr] ? sim_mem[mem_addr] : init_val(mem_addr);
    end else begin
      pipe[0] <= $urandom;
    end
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Reference model state
  logic [31:0] ref_mem [int];
  bit          last_own = 1'b1;  // 1 = debug port
  logic [31:0] cpu_rd_m = '0, dbg_rd_m = '0;
  int          n_pass = 0, n_total = 0;

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic bit pick(input bit c, input bit d);
    if (c && d) begin
`ifdef MEM_ARB_CPU_PRIO_EN
      return 1'b0;
`else
      return !last_own;
`endif
    end
    return d;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) a = a | 10'h3F8;
    return a;
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Called at a negedge in an IDLE cycle with the requests already driven.
  task automatic run_txn(input bit own, input bit we, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input int raise_k);
    int          dc;
    logic [31:0] rd;
    dc = we ? 2 : 2 + int'(LAT);
    rd = ref_rd(addr);
    if (we) ref_mem[int'(addr)] = wd;
    last_own = own;
    for (int k = 1; k <= dc; k++) begin
      @(negedge clk);
      if (k == dc && !we) begin
        if (own) dbg_rd_m = rd;
        else cpu_rd_m = rd;
      end
      chk1("cpu_gnt", cpu_gnt, k == 1 && !own);
      chk1("dbg_gnt", dbg_gnt, k == 1 && own);
      chk1("cpu_done", cpu_done, k == dc && !own);
      chk1("dbg_done", dbg_done, k == dc && own);
      chk1("mem_en", mem_en, k == 1);
      chk1("mem_we", mem_we, k == 1 && we);
      chk32("mem_addr", 32'(mem_addr), 32'(addr));
      chk1("busy", busy, 1'b1);
      if (k == 1 && we) chk32("mem_wdata", mem_wdata, wd);
      chk32("cpu_rdata", cpu_rdata, cpu_rd_m);
      chk32("dbg_rdata", dbg_rdata, dbg_rd_m);
      if (k == 1) begin
        if (own) dbg_req = 1'b0;
        else cpu_req = 1'b0;
      end
      if (k == raise_k) begin
        if (own) cpu_req = 1'b1;
        else dbg_req = 1'b1;
      end
    end
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_mem_en", mem_en, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cpu_pend, dbg_pend, own;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk1("rst_cpu_done", cpu_done, 1'b0);
    chk1("rst_dbg_done", dbg_done, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk32("rst_mem_wdata", mem_wdata, 32'd0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk32("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk1("post_rst_busy", busy, 1'b0);
    end

    // CPU write of 0x004
    cpu_we = 1'b1; cpu_addr = 10'h004; cpu_wdata = 32'hDEADBEEF; cpu_req = 1'b1;
    run_txn(1'b0, 1'b1, 10'h004, 32'hDEADBEEF, 0);

    // Debug write then read of 0x010; CPU read data must stay untouched
    dbg_we = 1'b1; dbg_addr = 10'h010; dbg_wdata = 32'h12345678; dbg_req = 1'b1;
    run_txn(1'b1, 1'b1, 10'h010, 32'h12345678, 0);
    dbg_we = 1'b0; dbg_req = 1'b1;
    run_txn(1'b1, 1'b0, 10'h010, 32'h0, 0);
    chk32("dbg_read_0x010", dbg_rdata, 32'h12345678);

    // Both ports requesting continuously for four transactions
    cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 32'hCAFE0001;
    dbg_we = 1'b0; dbg_addr = 10'h004;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_CPU_PRIO_EN
      own = 1'b0;
`else
      own = 1'(i % 2);
`endif
      cpu_req = 1'b1; dbg_req = 1'b1;
      if (own) run_txn(1'b1, 1'b0, 10'h004, 32'h0, 0);
      else run_txn(1'b0, 1'b1, 10'h020, 32'hCAFE0001, 0);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Reset during the WAIT phase of a CPU read
    cpu_we = 1'b0; cpu_addr = 10'h004; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk1("wait_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("abort_mem_en", mem_en, 1'b0);
    chk1("abort_mem_we", mem_we, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk32("abort_cpu_rdata", cpu_rdata, 32'd0);
    chk32("abort_dbg_rdata", dbg_rdata, 32'd0);
    cpu_rd_m = '0; dbg_rd_m = '0; last_own = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      @(negedge clk);
      chk1("abort_no_cpu_done", cpu_done, 1'b0);
      chk1("abort_idle", busy, 1'b0);
    end
    cpu_req = 1'b1;
    run_txn(1'b0, 1'b0, 10'h004, 32'h0, 0);
    chk32("post_abort_read", cpu_rdata, 32'hDEADBEEF);

    // Read of top address, CPU write right after, debug request arriving mid-write
    cpu_we = 1'b0; cpu_addr = 10'h3FF; cpu_req = 1'b1;
    run_txn(1'b0, 1'b0, 10'h3FF, 32'h0, 0);
    chk32("read_0x3ff", cpu_rdata, init_val(10'h3FF));
    cpu_we = 1'b1; cpu_wdata = 32'h0BAD_F00D; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 10'h3FF;
    run_txn(1'b0, 1'b1, 10'h3FF, 32'h0BAD_F00D, 1);
    run_txn(1'b1, 1'b0, 10'h3FF, 32'h0, 0);
    chk32("dbg_read_back_0x3ff", dbg_rdata, 32'h0BAD_F00D);

    // Random traffic: pending requests are held until granted
    cpu_pend = 1'b0; dbg_pend = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!cpu_pend && $urandom_range(0, 1) == 1) begin
        cpu_pend = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = $urandom; cpu_req = 1'b1;
      end
      if (!dbg_pend && $urandom_range(0, 1) == 1) begin
        dbg_pend = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = rand_addr(); dbg_wdata = $urandom; dbg_req = 1'b1;
      end
      if (!cpu_pend && !dbg_pend) begin
        cpu_pend = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = $urandom; cpu_req = 1'b1;
      end
      own = pick(cpu_pend, dbg_pend);
      if (own) begin
        dbg_pend = 1'b0;
        run_txn(1'b1, dbg_we, dbg_addr, dbg_wdata, 0);
      end else begin
        cpu_pend = 1'b0;
        run_txn(1'b0, cpu_we, cpu_addr, cpu_wdata, 0);
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
